// File: rtl/dm_multihart_pkg.sv
// ============================================================================
// Module : dm_multihart_pkg
// Brief  : Shared DMI addresses, cmderr codes, field positions and FSM states
//          for the multi-hart debug module.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dm_multihart_pkg;

    localparam int c_addr_data0        = 'h04;
    localparam int c_addr_dmcontrol    = 'h10;
    localparam int c_addr_dmstatus     = 'h11;
    localparam int c_addr_hartinfo     = 'h12;
    localparam int c_addr_abstractcs   = 'h16;
    localparam int c_addr_command      = 'h17;
    localparam int c_addr_abstractauto = 'h18;

    localparam logic [2:0] c_cmderr_none        = 3'd0;
    localparam logic [2:0] c_cmderr_busy        = 3'd1;
    localparam logic [2:0] c_cmderr_notsup      = 3'd2;
    localparam logic [2:0] c_cmderr_halt_resume = 3'd4;

    localparam int c_dmc_haltreq     = 31;
    localparam int c_dmc_resumereq   = 30;
    localparam int c_dmc_hartsel_lsb = 16;
    localparam int c_dmc_dmactive    = 0;
    localparam int c_acs_cmderr_lsb  = 8;
    localparam int c_cmd_write       = 16;
    localparam int c_cmd_transfer    = 17;
    localparam int c_cmd_postexec    = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_XFER  = 2'd2,
        ST_WAIT  = 2'd3
    } abs_state_t;

    // CSRs live in 0x0000-0x0FFF, GPRs in 0x1000-0x101F.
    function automatic logic regno_valid(input logic [15:0] regno);
        return (regno[15:12] == 4'h0) || (regno[15:5] == 11'h080);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dm_multihart_abs_cmd.sv
// ============================================================================
// Module : dm_multihart_abs_cmd
// Brief  : Abstract Access Register engine: validates the command, then runs
//          a req/ack register transfer on the selected hart.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dm_multihart_abs_cmd
    import dm_multihart_pkg::*;
#(
    parameter int XPR_LEN = 32,
    parameter int HSEL_W  = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               trigger,
    input  logic [31:0]        command,
    input  logic [HSEL_W-1:0]  hart,
    input  logic               hart_halted,
    input  logic [31:0]        data_lo,
    input  logic [31:0]        data_hi,
    output logic               busy,
    output logic               err_set,
    output logic [2:0]         err_code,
    output logic               done,
    output logic               done_hi,
    output logic [63:0]        done_data,
    output logic               dbg_req,
    output logic [HSEL_W-1:0]  dbg_hart,
    output logic               dbg_write,
    output logic [15:0]        dbg_regno,
    output logic [XPR_LEN-1:0] dbg_wdata,
    input  logic               dbg_ack,
    input  logic [XPR_LEN-1:0] dbg_rdata
);

    abs_state_t  r_state;
    logic [2:0]  w_aarsize;
    logic        w_size_ok;
    logic        w_unsupported;
    logic        w_in_xfer;
    logic [63:0] w_wdata64;
    logic        w_unused;

    assign w_aarsize     = command[22:20];
    assign w_size_ok     = (w_aarsize == 3'd2) || ((XPR_LEN == 64) && (w_aarsize == 3'd3));
    assign w_unsupported = (command[31:24] != 8'h00) || !w_size_ok ||
                           command[c_cmd_postexec] || !regno_valid(command[15:0]);
    assign w_wdata64     = (w_aarsize == 3'd3) ? {data_hi, data_lo} : {32'h0, data_lo};
    assign w_in_xfer     = (r_state == ST_XFER) || (r_state == ST_WAIT);

    assign busy      = (r_state != ST_IDLE);
    assign err_set   = (r_state == ST_CHECK) && (w_unsupported || !hart_halted);
    assign err_code  = w_unsupported ? c_cmderr_notsup : c_cmderr_halt_resume;
    assign done      = w_in_xfer && dbg_ack && !dbg_write && !clear;
    assign done_hi   = (w_aarsize == 3'd3);
    assign done_data = 64'(dbg_rdata);
    assign w_unused  = ^{command[23], command[19], w_wdata64};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            dbg_req   <= 1'b0;
            dbg_hart  <= '0;
            dbg_write <= 1'b0;
            dbg_regno <= 16'h0;
            dbg_wdata <= '0;
        end else if (clear) begin
            r_state <= ST_IDLE;
            dbg_req <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (trigger) r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (w_unsupported || !hart_halted || !command[c_cmd_transfer]) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state   <= ST_XFER;
                        dbg_req   <= 1'b1;
                        dbg_hart  <= hart;
                        dbg_write <= command[c_cmd_write];
                        dbg_regno <= command[15:0];
                        dbg_wdata <= w_wdata64[XPR_LEN-1:0];
                    end
                end
                default: begin
                    // Request fields stay frozen until the hart acknowledges.
                    if (dbg_ack) begin
                        r_state <= ST_IDLE;
                        dbg_req <= 1'b0;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/dm_multihart.sv
// ============================================================================
// Module : dm_multihart
// Brief  : Multi-hart RISC-V Debug Module (0.13 subset): DMI register file,
//          per-hart halt/resume and abstract register access commands.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dm_multihart
    import dm_multihart_pkg::*;
#(
    parameter int NUM_HARTS  = 4,
    parameter int XPR_LEN    = 32,
    parameter int DATA_COUNT = 2,
    parameter int ADDR_W     = 7,
    localparam int HSEL_W    = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDR_W-1:0]    dmi_addr,
    input  logic [31:0]          dmi_wdata,
    input  logic                 dmi_wen,
    input  logic                 dmi_ren,
    output logic [31:0]          dmi_rdata,
    output logic                 dm_busy,
    output logic [NUM_HARTS-1:0] core_haltreq,
    input  logic [NUM_HARTS-1:0] core_halted,
    output logic [NUM_HARTS-1:0] core_resumereq,
    input  logic [NUM_HARTS-1:0] core_resumeack,
    output logic                 dbg_req,
    output logic [HSEL_W-1:0]    dbg_hart,
    output logic                 dbg_write,
    output logic [15:0]          dbg_regno,
    output logic [XPR_LEN-1:0]   dbg_wdata,
    input  logic                 dbg_ack,
    input  logic [XPR_LEN-1:0]   dbg_rdata
);

    localparam logic [9:0] c_num_harts = 10'(NUM_HARTS);
    localparam int         c_hi_idx    = (DATA_COUNT > 1) ? 1 : 0;

    logic                  r_dmactive;
    logic                  r_haltreq_bit;
    logic [9:0]            r_hartsel;
    logic [31:0]           r_command;
    logic [DATA_COUNT-1:0] r_autoexec;
    logic [2:0]            r_cmderr;
    logic [31:0]           r_data [DATA_COUNT];
    logic [NUM_HARTS-1:0]  r_resumeack;

    logic [DATA_COUNT-1:0] w_data_sel;
    logic                  w_data_acc;
    logic                  w_dmc_wr, w_cmd_wr, w_acs_wr, w_auto_wr, w_data_wr, w_data_rd;
    logic                  w_active_next, w_busy, w_busy_err, w_trigger, w_clear;
    logic                  w_sel_exists, w_sel_halted, w_sel_ack;
    logic [HSEL_W-1:0]     w_sel_idx;
    logic [9:0]            w_wr_hartsel;
    logic                  w_abs_err, w_abs_done, w_abs_done_hi;
    logic [2:0]            w_abs_err_code;
    logic [63:0]           w_abs_done_data;
    logic [31:0]           w_data_hi;
    logic [31:0]           w_dmcontrol, w_dmstatus, w_abstractcs, w_rd_value;

    always_comb begin
        w_data_sel = '0;
        for (int i = 0; i < DATA_COUNT; i++)
            w_data_sel[i] = (dmi_addr == ADDR_W'(c_addr_data0 + i));
    end

    assign w_data_acc    = |w_data_sel;
    assign w_dmc_wr      = dmi_wen && (dmi_addr == ADDR_W'(c_addr_dmcontrol));
    assign w_cmd_wr      = r_dmactive && dmi_wen && (dmi_addr == ADDR_W'(c_addr_command));
    assign w_acs_wr      = r_dmactive && dmi_wen && (dmi_addr == ADDR_W'(c_addr_abstractcs));
    assign w_auto_wr     = r_dmactive && dmi_wen && (dmi_addr == ADDR_W'(c_addr_abstractauto));
    assign w_data_wr     = r_dmactive && dmi_wen && w_data_acc;
    assign w_data_rd     = r_dmactive && dmi_ren && w_data_acc;
    assign w_active_next = w_dmc_wr ? dmi_wdata[c_dmc_dmactive] : r_dmactive;
    assign w_clear       = !w_active_next;
    assign w_busy_err    = w_busy && (w_cmd_wr || w_acs_wr || w_auto_wr || w_data_wr || w_data_rd);
    // Autoexec fires on any access to an armed data register; the write lands first.
    assign w_trigger     = r_dmactive && !w_busy && (r_cmderr == c_cmderr_none) &&
                           (w_cmd_wr || ((w_data_wr || w_data_rd) && |(w_data_sel & r_autoexec)));

    assign w_wr_hartsel  = dmi_wdata[c_dmc_hartsel_lsb +: 10];
    assign w_sel_exists  = (r_hartsel < c_num_harts);
    assign w_sel_idx     = r_hartsel[HSEL_W-1:0];
    assign w_sel_halted  = w_sel_exists && core_halted[w_sel_idx];
    assign w_sel_ack     = w_sel_exists && r_resumeack[w_sel_idx];
    assign w_data_hi     = (DATA_COUNT > 1) ? r_data[c_hi_idx] : 32'h0;
    assign dm_busy       = w_busy;

    assign w_dmcontrol  = {r_haltreq_bit, 5'b0, r_hartsel, 15'b0, r_dmactive};
    assign w_dmstatus   = {14'b0, {2{w_sel_ack}}, {2{!w_sel_exists}}, 2'b0,
                           {2{w_sel_exists && !w_sel_halted}}, {2{w_sel_halted}},
                           1'b1, 3'b0, 4'd2};
    assign w_abstractcs = {19'b0, w_busy, 1'b0, r_cmderr, 4'b0, 4'(DATA_COUNT)};

    always_comb begin
        w_rd_value = 32'h0;
        if (w_data_acc) begin
            for (int i = 0; i < DATA_COUNT; i++)
                if (w_data_sel[i]) w_rd_value = r_data[i];
        end else if (dmi_addr == ADDR_W'(c_addr_dmcontrol)) begin
            w_rd_value = w_dmcontrol;
        end else if (dmi_addr == ADDR_W'(c_addr_dmstatus)) begin
            w_rd_value = w_dmstatus;
        end else if (dmi_addr == ADDR_W'(c_addr_abstractcs)) begin
            w_rd_value = w_abstractcs;
        end else if (dmi_addr == ADDR_W'(c_addr_command)) begin
            w_rd_value = r_command;
        end else if (dmi_addr == ADDR_W'(c_addr_abstractauto)) begin
            w_rd_value = 32'(r_autoexec);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    dmi_rdata <= 32'h0;
        else if (dmi_ren) dmi_rdata <= w_rd_value;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || w_clear) begin
            // Async reset and dmactive=0 both return the whole register file to reset.
            r_dmactive     <= 1'b0;
            r_haltreq_bit  <= 1'b0;
            r_hartsel      <= 10'h0;
            r_command      <= 32'h0;
            r_autoexec     <= '0;
            r_cmderr       <= c_cmderr_none;
            r_resumeack    <= '0;
            core_haltreq   <= '0;
            core_resumereq <= '0;
            for (int i = 0; i < DATA_COUNT; i++) r_data[i] <= 32'h0;
        end else begin
            if (w_dmc_wr) begin
                r_dmactive    <= 1'b1;
                r_haltreq_bit <= dmi_wdata[c_dmc_haltreq];
                r_hartsel     <= w_wr_hartsel;
            end
            if (w_cmd_wr && !w_busy)  r_command  <= dmi_wdata;
            if (w_auto_wr && !w_busy) r_autoexec <= dmi_wdata[DATA_COUNT-1:0];

            if (w_acs_wr && !w_busy)
                r_cmderr <= r_cmderr & ~dmi_wdata[c_acs_cmderr_lsb +: 3];
            else if ((r_cmderr == c_cmderr_none) && w_abs_err)
                r_cmderr <= w_abs_err_code;
            else if ((r_cmderr == c_cmderr_none) && w_busy_err)
                r_cmderr <= c_cmderr_busy;

            for (int i = 0; i < DATA_COUNT; i++)
                if (w_data_wr && !w_busy && w_data_sel[i]) r_data[i] <= dmi_wdata;
            if (w_abs_done) begin
                r_data[0] <= w_abs_done_data[31:0];
                if (w_abs_done_hi && (DATA_COUNT > 1)) r_data[c_hi_idx] <= w_abs_done_data[63:32];
            end

            for (int h = 0; h < NUM_HARTS; h++) begin
                if (core_resumeack[h]) begin
                    core_resumereq[h] <= 1'b0;
                    r_resumeack[h]    <= 1'b1;
                end
                if (w_dmc_wr && (w_wr_hartsel == 10'(h))) begin
                    core_haltreq[h] <= dmi_wdata[c_dmc_haltreq];
                    if (dmi_wdata[c_dmc_resumereq] && !dmi_wdata[c_dmc_haltreq] && core_halted[h]) begin
                        r_resumeack[h]    <= 1'b0;
                        core_resumereq[h] <= 1'b1;
                    end
                end
            end
        end
    end

    dm_multihart_abs_cmd #(
        .XPR_LEN (XPR_LEN),
        .HSEL_W  (HSEL_W)
    ) u_abs_cmd (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (w_clear),
        .trigger     (w_trigger),
        .command     (r_command),
        .hart        (w_sel_idx),
        .hart_halted (w_sel_halted),
        .data_lo     (r_data[0]),
        .data_hi     (w_data_hi),
        .busy        (w_busy),
        .err_set     (w_abs_err),
        .err_code    (w_abs_err_code),
        .done        (w_abs_done),
        .done_hi     (w_abs_done_hi),
        .done_data   (w_abs_done_data),
        .dbg_req     (dbg_req),
        .dbg_hart    (dbg_hart),
        .dbg_write   (dbg_write),
        .dbg_regno   (dbg_regno),
        .dbg_wdata   (dbg_wdata),
        .dbg_ack     (dbg_ack),
        .dbg_rdata   (dbg_rdata)
    );

endmodule

`default_nettype wire
